// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. buffered long-latency results.
// Latency: RF outputs are combinational (pipeline and bypass have zero latency); buffered results drain in FIFO order.
// Backpressure: lu_ready_o drops when the buffer is full; stall_o holds the pipeline for one cycle to force a drain.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_wb_en_i,
    input  logic [REG_AW-1:0]             pipe_wb_rd_i,
    input  logic [DATA_W-1:0]             pipe_wb_data_i,
    input  logic                          lu_valid_i,
    input  logic [REG_AW-1:0]             lu_rd_i,
    input  logic [DATA_W-1:0]             lu_data_i,
    output logic                          lu_ready_o,
    output logic                          stall_o,
    output logic                          rf_we_o,
    output logic [REG_AW-1:0]             rf_waddr_o,
    output logic [DATA_W-1:0]             rf_wdata_o,
    input  logic [REG_AW-1:0]             query_rd_i,
    output logic                          query_hit_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // Result buffer storage; only the count register decides which slots are live.
    logic [REG_AW-1:0] rd_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stall_q;

    logic              empty;
    logic              full;
    logic              pipe_req;
    logic              lu_acc;
    logic              lu_wr;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Grant selection for the single write port, highest priority first.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CNT_W'(FIFO_DEPTH));
        pipe_req = pipe_wb_en_i && (pipe_wb_rd_i != '0);
        lu_acc   = lu_valid_i && !full;
        // x0 results complete the handshake but are dropped here.
        lu_wr    = lu_acc && (lu_rd_i != '0);
        pop      = 1'b0;
        bypass   = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        if (stall_q && !empty) begin
            pop = 1'b1;
        end else if (pipe_req) begin
            we    = 1'b1;
            waddr = pipe_wb_rd_i;
            wdata = pipe_wb_data_i;
        end else if (!empty) begin
            pop = 1'b1;
        end else if (lu_wr) begin
            bypass = 1'b1;
            we     = 1'b1;
            waddr  = lu_rd_i;
            wdata  = lu_data_i;
        end
        if (pop) begin
            we    = 1'b1;
            waddr = rd_mem[rd_ptr];
            wdata = data_mem[rd_ptr];
        end
        // lu_ready_o is 0 when full, so a push never coincides with a full buffer.
        push = lu_wr && !bypass;
    end

    // Outputs are forced to their idle values while reset is held so nothing reaches the RF.
    always_comb begin
        rf_we_o      = we && rst_n;
        rf_waddr_o   = rst_n ? waddr : '0;
        rf_wdata_o   = rst_n ? wdata : '0;
        lu_ready_o   = !full;
        stall_o      = stall_q;
        fifo_count_o = count;
    end

    // Buffer payload write; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= lu_rd_i;
            data_mem[wr_ptr] <= lu_data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation tracking: the head's wait time and the one-cycle forced-drain stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (empty || pop) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (empty || pop) begin
                stall_q <= 1'b0;
            end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                stall_q <= 1'b1;
            end
        end
    end

    // Hazard lookup over live buffer entries and the result arriving this cycle; x0 never hits.
    always_comb begin
        logic [PTR_W-1:0] off;
        query_hit_o = 1'b0;
        off         = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(off) < count) && (rd_mem[i] == query_rd_i)) begin
                query_hit_o = 1'b1;
            end
        end
        if (lu_valid_i && (lu_rd_i == query_rd_i)) begin
            query_hit_o = 1'b1;
        end
        if (query_rd_i == '0) begin
            query_hit_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus an async-reset sequence.
// Latency: each vector is one clock; outputs are sampled 1 time unit after inputs settle at negedge.
// Backpressure: lu inputs are held by the table itself while lu_ready_o is 0.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_wb_en_i;
    logic [4:0]  pipe_wb_rd_i;
    logic [31:0] pipe_wb_data_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  query_rd_i;
    logic        query_hit_o;
    logic [1:0]  fifo_count_o;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .DATA_W(32), .REG_AW(5), .FIFO_DEPTH(2), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_en_i(pipe_wb_en_i), .pipe_wb_rd_i(pipe_wb_rd_i), .pipe_wb_data_i(pipe_wb_data_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i), .lu_ready_o(lu_ready_o),
        .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .query_rd_i(query_rd_i), .query_hit_o(query_hit_o), .fifo_count_o(fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic [4:0]  qrd;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        rdy;
        logic [1:0]  cnt;
        logic        hit;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic pe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] qrd,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic st, input logic rdy, input logic [1:0] cnt, input logic hit);
        vec_t v;
        v.pe = pe; v.prd = prd; v.pd = pd; v.lv = lv; v.lrd = lrd; v.ld = ld; v.qrd = qrd;
        v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.rdy = rdy; v.cnt = cnt; v.hit = hit;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pe, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] qrd);
        pipe_wb_en_i = pe; pipe_wb_rd_i = prd; pipe_wb_data_i = pd;
        lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ld; query_rd_i = qrd;
    endtask

    task automatic chk_all(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic st, input logic rdy,
                           input logic [1:0] cnt, input logic hit);
        chk({tag, ".rf_we"},   32'(rf_we_o),      32'(we));
        chk({tag, ".waddr"},   32'(rf_waddr_o),   32'(wa));
        chk({tag, ".wdata"},   rf_wdata_o,        wd);
        chk({tag, ".stall"},   32'(stall_o),      32'(st));
        chk({tag, ".lu_rdy"},  32'(lu_ready_o),   32'(rdy));
        chk({tag, ".count"},   32'(fifo_count_o), 32'(cnt));
        chk({tag, ".qhit"},    32'(query_hit_o),  32'(hit));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;

        //   pe prd pd          lv lrd ld          qrd | we wa wd          st rdy cnt hit
        // reset state and zero-latency bypass
        add(0, 0, 0,           0, 0,  0,           0,   0, 0,  0,           0, 1, 0, 0);
        add(0, 0, 0,           1, 5,  32'hDEAD,    5,   1, 5,  32'hDEAD,    0, 1, 0, 1);
        add(0, 0, 0,           0, 0,  0,           0,   0, 0,  0,           0, 1, 0, 0);
        // pipeline priority, result buffered then drained
        add(1, 3, 32'h11,      1, 7,  32'h22,      7,   1, 3,  32'h11,      0, 1, 0, 1);
        add(0, 0, 0,           0, 0,  0,           7,   1, 7,  32'h22,      0, 1, 1, 1);
        add(0, 0, 0,           0, 0,  0,           7,   0, 0,  0,           0, 1, 0, 0);
        // starvation: four pipeline wins, then one stall cycle drains the head
        add(1, 3, 32'h30,      1, 9,  32'h99,      0,   1, 3,  32'h30,      0, 1, 0, 0);
        add(1, 4, 32'h31,      0, 0,  0,           9,   1, 4,  32'h31,      0, 1, 1, 1);
        add(1, 4, 32'h32,      0, 0,  0,           0,   1, 4,  32'h32,      0, 1, 1, 0);
        add(1, 4, 32'h33,      0, 0,  0,           0,   1, 4,  32'h33,      0, 1, 1, 0);
        add(1, 4, 32'h34,      0, 0,  0,           0,   1, 4,  32'h34,      0, 1, 1, 0);
        add(1, 4, 32'h35,      0, 0,  0,           0,   1, 9,  32'h99,      1, 1, 1, 0);
        add(1, 4, 32'h35,      0, 0,  0,           0,   1, 4,  32'h35,      0, 1, 0, 0);
        // full buffer, held third result, order A, B, C preserved
        add(1, 1, 32'h40,      1, 10, 32'hA,       0,   1, 1,  32'h40,      0, 1, 0, 0);
        add(1, 1, 32'h41,      1, 11, 32'hB,       10,  1, 1,  32'h41,      0, 1, 1, 1);
        add(1, 1, 32'h42,      1, 12, 32'hC,       12,  1, 1,  32'h42,      0, 0, 2, 1);
        add(1, 1, 32'h43,      1, 12, 32'hC,       11,  1, 1,  32'h43,      0, 0, 2, 1);
        add(1, 1, 32'h44,      1, 12, 32'hC,       0,   1, 1,  32'h44,      0, 0, 2, 0);
        add(1, 1, 32'h45,      1, 12, 32'hC,       0,   1, 10, 32'hA,       1, 0, 2, 0);
        add(1, 1, 32'h45,      1, 12, 32'hC,       0,   1, 1,  32'h45,      0, 1, 1, 0);
        add(0, 0, 0,           0, 0,  0,           0,   1, 11, 32'hB,       0, 0, 2, 0);
        add(0, 0, 0,           0, 0,  0,           12,  1, 12, 32'hC,       0, 1, 1, 1);
        add(0, 0, 0,           0, 0,  0,           0,   0, 0,  0,           0, 1, 0, 0);
        // x0 destinations: accepted/dropped long-latency result, ignored pipeline write
        add(0, 0, 0,           1, 0,  32'h77,      0,   0, 0,  0,           0, 1, 0, 0);
        add(0, 0, 0,           0, 0,  0,           0,   0, 0,  0,           0, 1, 0, 0);
        add(1, 0, 32'h55,      0, 0,  0,           0,   0, 0,  0,           0, 1, 0, 0);
        add(0, 0, 0,           0, 0,  0,           0,   0, 0,  0,           0, 1, 0, 0);

        // idle values while reset is held
        #1;
        chk_all("in_reset", 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].pe, vq[i].prd, vq[i].pd, vq[i].lv, vq[i].lrd, vq[i].ld, vq[i].qrd);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].we, vq[i].wa, vq[i].wd,
                    vq[i].st, vq[i].rdy, vq[i].cnt, vq[i].hit);
        end

        // Async reset with two entries buffered and stall asserted.
        @(negedge clk); drive(1, 2, 32'h60, 1, 13, 32'hD, 0);
        @(negedge clk); drive(1, 2, 32'h61, 1, 14, 32'hE, 0);
        @(negedge clk); drive(1, 2, 32'h62, 0, 0, 0, 13);
        @(negedge clk); drive(1, 2, 32'h63, 0, 0, 0, 13);
        @(negedge clk); drive(1, 2, 32'h64, 0, 0, 0, 13);
        @(negedge clk); drive(1, 2, 32'h65, 0, 0, 0, 13);
        #1;
        chk_all("pre_rst", 1, 13, 32'hD, 1, 0, 2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 13);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0, 1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
